// File: rtl/cmp_pkg.sv
// cmp_pkg: shared compare width, result type and operand conditioning
package cmp_pkg;
  localparam int CMP_W = 32;
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;
  function automatic logic [CMP_W-1:0] cmp_condition(logic [CMP_W-1:0] x, logic sgn);
    return {x[CMP_W-1] ^ sgn, x[CMP_W-2:0]};
  endfunction
endpackage

// File: rtl/comparator_32bits.sv
// comparator_32bits: unsigned magnitude comparator
module comparator_32bits
  import cmp_pkg::*;
(
  input  logic [CMP_W-1:0] i_a,
  input  logic [CMP_W-1:0] i_b,
  output logic             o_eq,
  output logic             o_lt,
  output logic             o_gt
);
  assign o_eq = i_a == i_b;
  assign o_lt = i_a < i_b;
  assign o_gt = i_a > i_b;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting the search at i_ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);
  logic [IW-1:0] k;
  // scan offsets from the far end down so the smallest rotated offset wins
  always_comb begin
    o_grant = '0;
    o_grant_idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(i_ptr) + i) % N);
      if (i_en && i_req[k]) begin
        o_grant = '0;
        o_grant[k] = 1'b1;
        o_grant_idx = k;
      end
    end
  end
endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one comparator with a two-stage pipeline
module cmp_share_arbiter
  import cmp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*CMP_W-1:0] i_req_a,
  input  logic [N_REQ*CMP_W-1:0] i_req_b,
  input  logic [N_REQ-1:0]       i_req_signed,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic                   o_rsp_eq,
  output logic                   o_rsp_lt,
  output logic                   o_rsp_gt,
  output logic                   o_busy
);
  logic adv1, adv2, s1_valid, s2_valid, c_eq, c_lt, c_gt;
  logic [ID_W-1:0] rr_ptr, gidx, s1_id, s2_id;
  logic [CMP_W-1:0] s1_a, s1_b;
  logic [CMP_W-1:0] req_a [N_REQ];
  logic [CMP_W-1:0] req_b [N_REQ];
  cmp_result_t s2_res;
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_a[k] = i_req_a[k*CMP_W +: CMP_W];
    assign req_b[k] = i_req_b[k*CMP_W +: CMP_W];
  end
  assign adv2 = ~s2_valid | i_rsp_ready;
  assign adv1 = ~s1_valid | adv2;
  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .i_req      (i_req_valid),
    .i_en       (adv1 & i_rst_n),
    .i_ptr      (rr_ptr),
    .o_grant    (o_req_ready),
    .o_grant_idx(gidx)
  );
  comparator_32bits u_cmp (
    .i_a (s1_a),
    .i_b (s1_b),
    .o_eq(c_eq),
    .o_lt(c_lt),
    .o_gt(c_gt)
  );
  // stage 1: capture the granted request with sign-conditioned operands
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      rr_ptr <= '0;
    end else if (adv1) begin
      s1_valid <= |o_req_ready;
      if (|o_req_ready) begin
        s1_a <= cmp_condition(req_a[gidx], i_req_signed[gidx]);
        s1_b <= cmp_condition(req_b[gidx], i_req_signed[gidx]);
        s1_id <= gidx;
        rr_ptr <= gidx == ID_W'(N_REQ - 1) ? '0 : gidx + 1'b1;
      end
    end
  end
  // stage 2: register the comparator result until the consumer takes it
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_res <= '0;
      s2_id <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      s2_res <= {c_eq, c_lt, c_gt};
      s2_id <= s1_id;
    end
  end
  assign o_rsp_valid = s2_valid;
  assign o_rsp_id = s2_id;
  assign {o_rsp_eq, o_rsp_lt, o_rsp_gt} = s2_valid ? s2_res : '0;
  assign o_busy = s1_valid | s2_valid;
endmodule
